// File: rtl/m_64spi_queue.sv
// Request FIFO in front of a 64-bit SPI engine; one transfer in flight, response held until consumed.
// Optional watchdog on stuck transfers: define XFER_TIMEOUT_EN.
module m_64spi_queue #(
   parameter int DEPTH          = 4,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic        clk,
   input  logic        I_RESETN,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [63:0] req_data,
   output logic        xfer_start,
   output logic [63:0] xfer_out,
   input  logic [63:0] xfer_in,
   input  logic        xfer_status,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_data,
   output logic        busy,
   output logic [4:0]  req_count,
   output logic [15:0] xfer_cnt,
   output logic        err
);
   localparam int         PW      = $clog2(DEPTH);
   localparam logic [4:0] DEPTH_W = 5'(DEPTH);

   if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 ||
       TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
      $error("m_64spi_queue: illegal DEPTH or TIMEOUT_CYCLES");
   end

   typedef enum logic [2:0] {IDLE, START, WAIT_HI, WAIT_LO, CAPTURE, RSP} state_t;

   state_t        r_state;
   logic [63:0]   r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [4:0]    r_count;
   logic          w_push;
   logic          w_pop;
   logic          w_tmo_hit;

   assign req_ready = (r_count < DEPTH_W);
   assign req_count = r_count;
   assign busy      = (r_state != IDLE);
   assign w_push    = req_valid && req_ready;
   // A pop is exactly the IDLE->START transition; status must be low so a stale engine can't be restarted.
   assign w_pop     = (r_state == IDLE) && (r_count != '0) && !rsp_valid && !xfer_status;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= req_data;
   end

   always_ff @(posedge clk or negedge I_RESETN) begin
      if (!I_RESETN) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 5'd1;
            2'b01:   r_count <= r_count - 5'd1;
            default: r_count <= r_count;
         endcase
      end
   end

`ifdef XFER_TIMEOUT_EN
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] r_tmo;
   logic        r_err;

   assign w_tmo_hit = ((r_state == WAIT_HI) || (r_state == WAIT_LO)) && (r_tmo == TMO_LAST);
   assign err       = r_err;

   always_ff @(posedge clk or negedge I_RESETN) begin
      if (!I_RESETN) begin
         r_tmo <= '0;
         r_err <= 1'b0;
      end else begin
         if (r_state == START) r_tmo <= '0;
         else if ((r_state == WAIT_HI) || (r_state == WAIT_LO)) r_tmo <= r_tmo + 16'd1;
         if (w_tmo_hit) r_err <= 1'b1;
      end
   end
`else
   assign w_tmo_hit = 1'b0;
   assign err       = 1'b0;
`endif

   always_ff @(posedge clk or negedge I_RESETN) begin
      if (!I_RESETN) begin
         r_state    <= IDLE;
         xfer_start <= 1'b0;
         xfer_out   <= '0;
         rsp_valid  <= 1'b0;
         rsp_data   <= '0;
         xfer_cnt   <= '0;
      end else if (w_tmo_hit) begin
         xfer_start <= 1'b0;
         rsp_data   <= 64'hDEAD_DEAD_DEAD_DEAD;
         rsp_valid  <= 1'b1;
         r_state    <= RSP;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_pop) begin
                  xfer_out   <= r_mem[r_rd_ptr];
                  xfer_start <= 1'b1;
                  r_state    <= START;
               end
            end
            START: r_state <= WAIT_HI;
            WAIT_HI: begin
               if (xfer_status) begin
                  xfer_start <= 1'b0;
                  r_state    <= WAIT_LO;
               end
            end
            WAIT_LO: begin
               if (!xfer_status) r_state <= CAPTURE;
            end
            CAPTURE: begin
               rsp_data  <= xfer_in;
               rsp_valid <= 1'b1;
               xfer_cnt  <= xfer_cnt + 16'd1;
               r_state   <= RSP;
            end
            RSP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  r_state   <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_m_64spi_queue.sv
// Scoreboard bench for m_64spi_queue; engine model returns the bitwise inverse of the transmitted word.
module tb_m_64spi_queue;
   logic        clk = 1'b0;
   logic        I_RESETN = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [63:0] req_data = '0;
   logic        xfer_start;
   logic [63:0] xfer_out;
   logic [63:0] xfer_in = '0;
   logic        xfer_status = 1'b0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [63:0] rsp_data;
   logic        busy;
   logic [4:0]  req_count;
   logic [15:0] xfer_cnt;
   logic        err;

   int          checks = 0;
   int          failures = 0;
   logic [63:0] exp_rsp [$];
   logic [15:0] exp_cnt = '0;

   logic        eng_en = 1'b1;
   logic        eng_stuck = 1'b0;
   logic        eng_active = 1'b0;
   int          eng_len = 3;
   int          eng_cnt = 0;
   logic [63:0] eng_word = '0;

   m_64spi_queue #(.DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .I_RESETN(I_RESETN),
      .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
      .xfer_start(xfer_start), .xfer_out(xfer_out), .xfer_in(xfer_in),
      .xfer_status(xfer_status), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .busy(busy), .req_count(req_count),
      .xfer_cnt(xfer_cnt), .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL global_timeout");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "simulation time limit");
   end

   // Engine: status rises half a cycle after start is seen, stays high eng_len cycles, then returns ~word.
   always @(negedge clk) begin
      if (!I_RESETN) eng_active = 1'b0;
      if (eng_stuck) xfer_status = 1'b1;
      else if (eng_active) begin
         if (eng_cnt >= eng_len) begin
            xfer_in     = ~eng_word;
            xfer_status = 1'b0;
            eng_active  = 1'b0;
         end else eng_cnt++;
      end else begin
         xfer_status = 1'b0;
         if (eng_en && xfer_start && I_RESETN) begin
            eng_word    = xfer_out;
            eng_active  = 1'b1;
            eng_cnt     = 1;
            xfer_status = 1'b1;
         end
      end
   end

   task automatic push_word(input logic [63:0] w);
      bit ok = 0;
      req_valid = 1'b1;
      req_data  = w;
      for (int c = 0; c < 200; c++) begin
         if (req_ready) begin
            @(posedge clk);
            ok = 1;
            break;
         end
         @(posedge clk); #1;
      end
      if (ok) #1;
      req_valid = 1'b0;
      if (ok) exp_rsp.push_back(~w);
      else begin
         checks++; failures++;
         $display("FAIL push_accept word=%h not accepted within bound", w);
      end
   endtask

   task automatic collect(input int n, input int budget);
      int got = 0;
      logic [63:0] e;
      for (int c = 0; c < budget && got < n; c++) begin
         if (rsp_valid && rsp_ready) begin
            checks++;
            if (exp_rsp.size() == 0) begin
               failures++;
               $display("FAIL rsp_unexpected got=%h", rsp_data);
            end else begin
               e = exp_rsp.pop_front();
               if (rsp_data !== e) begin
                  failures++;
                  $display("FAIL rsp_data got=%h exp=%h", rsp_data, e);
               end
            end
            exp_cnt = exp_cnt + 16'd1;
            checks++;
            if (xfer_cnt !== exp_cnt) begin
               failures++;
               $display("FAIL xfer_cnt got=%h exp=%h", xfer_cnt, exp_cnt);
            end
            got++;
         end
         @(posedge clk); #1;
      end
      if (got < n) begin
         checks++; failures++;
         $display("FAIL rsp_wait got=%0d responses exp=%0d", got, n);
      end
   endtask

   task automatic test_reset();
      I_RESETN = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({busy, xfer_start, rsp_valid, err, req_ready} !== 5'b00001) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=00001", {busy, xfer_start, rsp_valid, err, req_ready});
      end
      checks++;
      if ({xfer_out, rsp_data, xfer_cnt, req_count} !== '0) begin
         failures++;
         $display("FAIL reset_values out=%h rsp=%h cnt=%h count=%0d", xfer_out, rsp_data, xfer_cnt, req_count);
      end
      @(negedge clk) I_RESETN = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      eng_en = 1'b1; eng_len = 100;
      push_word(64'h0123_4567_89AB_CDEF);
      checks++;
      if (xfer_start !== 1'b0) begin
         failures++;
         $display("FAIL start_early got=%b exp=0", xfer_start);
      end
      @(posedge clk); #1;
      checks++;
      if (xfer_start !== 1'b1 || busy !== 1'b1) begin
         failures++;
         $display("FAIL start_latency start=%b busy=%b exp=1 1", xfer_start, busy);
      end
      checks++;
      if (xfer_out !== 64'h0123_4567_89AB_CDEF) begin
         failures++;
         $display("FAIL xfer_out got=%h exp=0123456789abcdef", xfer_out);
      end
      collect(1, 300);
      eng_len = 3;
   endtask

   task automatic test_fill();
      logic [63:0] w;
      eng_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         w = {32'hA5A5_0000 + 32'(i), 32'h1000_0000 * 32'(i + 1)};
         push_word(w);
      end
      checks++;
      if (req_count !== 5'd4 || req_ready !== 1'b0) begin
         failures++;
         $display("FAIL fifo_full count=%0d ready=%b exp=4 0", req_count, req_ready);
      end
      req_valid = 1'b1;
      req_data  = 64'hBAD0_BAD0_BAD0_BAD0;
      repeat (5) begin @(posedge clk); #1; end
      req_valid = 1'b0;
      checks++;
      if (req_count !== 5'd4 || xfer_start !== 1'b1) begin
         failures++;
         $display("FAIL overflow_hold count=%0d start=%b exp=4 1", req_count, xfer_start);
      end
      eng_en = 1'b1;
      collect(5, 300);
      checks++;
      if (req_count !== 5'd0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL drain count=%0d busy=%b exp=0 0", req_count, busy);
      end
   endtask

   task automatic test_backpressure();
      logic [63:0] held;
      int bad = 0;
      int c = 0;
      rsp_ready = 1'b0;
      eng_len = 2;
      push_word(64'h1111_2222_3333_4444);
      push_word(64'h5555_6666_7777_8888);
      push_word(64'h9999_AAAA_BBBB_CCCC);
      while (!rsp_valid && c < 50) begin @(posedge clk); #1; c++; end
      held = rsp_data;
      checks++;
      if (rsp_valid !== 1'b1 || held !== exp_rsp[0]) begin
         failures++;
         $display("FAIL first_rsp valid=%b got=%h exp=%h", rsp_valid, held, exp_rsp[0]);
      end
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         if (rsp_valid !== 1'b1 || rsp_data !== held || xfer_start !== 1'b0 || req_count !== 5'd2) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL backpressure_hold bad_cycles=%0d exp=0", bad);
      end
      rsp_ready = 1'b1;
      collect(3, 200);
      eng_len = 3;
   endtask

   task automatic test_reset_mid();
      int bad = 0;
      eng_len = 1000;
      push_word(64'hC0DE_0000_0000_0001);
      push_word(64'hC0DE_0000_0000_0002);
      push_word(64'hC0DE_0000_0000_0003);
      push_word(64'hC0DE_0000_0000_0004);
      checks++;
      if (busy !== 1'b1 || xfer_start !== 1'b0 || req_count !== 5'd3) begin
         failures++;
         $display("FAIL wait_lo_entry busy=%b start=%b count=%0d exp=1 0 3", busy, xfer_start, req_count);
      end
      eng_stuck = 1'b1;
      #2 I_RESETN = 1'b0;
      #1;
      checks++;
      if ({busy, xfer_start, rsp_valid, err, req_ready} !== 5'b00001 ||
          {xfer_out, rsp_data, xfer_cnt, req_count} !== '0) begin
         failures++;
         $display("FAIL async_reset flags=%b out=%h cnt=%h count=%0d", {busy, xfer_start, rsp_valid, err, req_ready},
                  xfer_out, xfer_cnt, req_count);
      end
      exp_rsp.delete();
      exp_cnt = '0;
      eng_len = 3;
      @(negedge clk) I_RESETN = 1'b1;
      @(posedge clk); #1;
      push_word(64'h0F0F_F0F0_1234_5678);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (xfer_start !== 1'b0 || busy !== 1'b0 || req_count !== 5'd1) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL start_while_status_high bad_cycles=%0d exp=0", bad);
      end
      eng_stuck = 1'b0;
      collect(1, 100);
   endtask

   task automatic test_wrap();
      force dut.xfer_cnt = 16'hFFFF;
      #1 release dut.xfer_cnt;
      exp_cnt = 16'hFFFF;
      push_word(64'hFFFF_0000_FFFF_0000);
      collect(1, 100);
      checks++;
      if (xfer_cnt !== 16'h0000) begin
         failures++;
         $display("FAIL cnt_wrap got=%h exp=0000", xfer_cnt);
      end
   endtask

   task automatic test_timeout();
`ifdef XFER_TIMEOUT_EN
      int n = 0;
      eng_len = 100000;
      push_word(64'h7777_7777_7777_7777);
      void'(exp_rsp.pop_back());
      @(posedge clk); #1;
      while (!rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
      checks++;
      if (n != 17 || rsp_data !== 64'hDEAD_DEAD_DEAD_DEAD || err !== 1'b1 || xfer_cnt !== exp_cnt) begin
         failures++;
         $display("FAIL timeout cycles=%0d data=%h err=%b cnt=%h exp=17 deaddeaddeaddead 1 %h",
                  n, rsp_data, err, xfer_cnt, exp_cnt);
      end
      @(posedge clk); #1;
      I_RESETN = 1'b0;
      eng_len = 3;
      @(negedge clk) I_RESETN = 1'b1;
      exp_cnt = '0;
      @(posedge clk); #1;
`else
      eng_len = 40;
      push_word(64'h7777_7777_7777_7777);
      collect(1, 200);
      checks++;
      if (err !== 1'b0) begin
         failures++;
         $display("FAIL err_const got=%b exp=0", err);
      end
      eng_len = 3;
`endif
   endtask

   initial begin
      test_reset();
      test_basic();
      test_fill();
      test_backpressure();
      test_reset_mid();
      test_wrap();
      test_timeout();
      checks++;
      if (exp_rsp.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_leftover entries=%0d exp=0", exp_rsp.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/m_64spi_queue.md
M_64SPI_QUEUE -- requirements
Module: m_64spi_queue

Interface
REQ-001 Parameter DEPTH, default 4, request FIFO depth in 64-bit words; SHALL be a power of two, 2..16.
REQ-002 Parameter TIMEOUT_CYCLES, default 4096, per-transfer watchdog limit; used only when XFER_TIMEOUT_EN is defined.
REQ-003 Ports SHALL be:
  clk  in  1  single clock, all logic on posedge
  I_RESETN  in  1  asynchronous active-low reset
  req_valid  in  1  request word offered
  req_ready  out  1  FIFO can accept a word
  req_data  in  64  word to transmit
  xfer_start  out  1  to 64-bit SPI engine start
  xfer_out  out  64  to engine out, word being transmitted
  xfer_in  in  64  from engine in, received word
  xfer_status  in  1  from engine status, 1 = transfer in progress
  rsp_valid  out  1  received word available
  rsp_ready  in  1  consumer accepts received word
  rsp_data  out  64  received word
  busy  out  1  FSM not in IDLE
  req_count  out  5  FIFO occupancy, 0..DEPTH
  xfer_cnt  out  16  completed transfers, wraps 0xFFFF->0x0000
  err  out  1  sticky timeout flag

Function
REQ-010 The FIFO SHALL push req_data when req_valid && req_ready; req_ready SHALL equal (req_count < DEPTH).
REQ-011 Full FIFO: req_ready=0, no push. Empty FIFO: no pop. Push and pop in the same cycle SHALL leave req_count unchanged. Pointers SHALL wrap modulo DEPTH.
REQ-012 FSM states SHALL be IDLE, START, WAIT_HI, WAIT_LO, CAPTURE, RSP.
REQ-013 IDLE->START when req_count>0, rsp_valid=0 and xfer_status=0; the transition SHALL pop the head word into xfer_out.
REQ-014 START: xfer_start=1, xfer_out stable; ->WAIT_HI next cycle.
REQ-015 WAIT_HI: xfer_start held 1 until xfer_status=1 is sampled, then xfer_start=0 on the next edge and ->WAIT_LO.
REQ-016 WAIT_LO: ->CAPTURE when xfer_status=0 is sampled.
REQ-017 CAPTURE: rsp_data<=xfer_in, rsp_valid<=1, xfer_cnt<=xfer_cnt+1; ->RSP.
REQ-018 RSP: rsp_valid and rsp_data held until rsp_ready=1 is sampled; then rsp_valid<=0 and ->IDLE.
REQ-019 Minimum latency from push into an empty FIFO to xfer_start=1 SHALL be 2 cycles.
REQ-020 xfer_out SHALL change only on the IDLE->START transition.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 The next transfer SHALL NOT start while rsp_valid=1 (response backpressure).

Reset
REQ-030 I_RESETN=0 SHALL asynchronously force FSM=IDLE, FIFO empty, req_count=0, xfer_start=0, xfer_out=0, rsp_valid=0, rsp_data=0, xfer_cnt=0, err=0, busy=0, req_ready=1.
REQ-031 Reset mid-transfer SHALL discard the in-flight word and all queued words; after release, no transfer SHALL start until xfer_status=0 is sampled.

Configuration
REQ-040 Macro XFER_TIMEOUT_EN defined: a 16-bit counter SHALL clear on entry to WAIT_HI and increment each cycle in WAIT_HI/WAIT_LO; on reaching TIMEOUT_CYCLES the FSM SHALL set err=1 (sticky until reset), load rsp_data=64'hDEAD_DEAD_DEAD_DEAD, set rsp_valid=1, drop xfer_start, leave xfer_cnt unchanged, and go to RSP.
REQ-041 Macro not defined: no counter SHALL exist, err SHALL be constant 0, WAIT_HI/WAIT_LO wait indefinitely.

Verification
REQ-050 Push 64'h0123_4567_89AB_CDEF; engine model raises status 1 cycle after start, lowers after 100 cycles with in=64'hFEDC_BA98_7654_3210 -> xfer_out matches, rsp_data=64'hFEDC_BA98_7654_3210, xfer_cnt=1.
REQ-051 Push 5 words with DEPTH=4 and no engine response -> first pops immediately, next 4 fill FIFO, req_ready=0 at req_count=4; after completions all 5 responses return in order.
REQ-052 Hold rsp_ready=0 for 50 cycles after first response with 2 words queued -> rsp_valid/rsp_data stable, xfer_start stays 0 until rsp_ready=1.
REQ-053 Assert I_RESETN=0 in WAIT_LO with 3 words queued, xfer_status held 1 after release -> all outputs at reset values, no xfer_start until xfer_status=0.
REQ-054 XFER_TIMEOUT_EN, TIMEOUT_CYCLES=16, status never falls -> err=1 and rsp_data=64'hDEAD_DEAD_DEAD_DEAD after 16 cycles, xfer_cnt unchanged.
REQ-055 Preload xfer_cnt to 0xFFFF via 65535 transfers (or forced), one more transfer -> xfer_cnt=0x0000.
